uart_tx_arbiter: RTL and testbench

Shares the single UART transmit engine between several on-board byte sources, such as the echo path and debug/status reporters. It arbitrates between them round-robin and keeps multi-byte messages contiguous. It runs on the 29.49 MHz system clock and stretches its trigger so the slower baud-domain transmitter always samples it. Each byte is sequenced through trigger, busy-rise and busy-fall, with a watchdog.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: arbiter state encoding, default trigger length and busy
// watchdog limit, grant index width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Trigger high time must cover one full baud-clock period.
  localparam int unsigned TRIG_CYCLES_DEF  = 16;
  localparam int unsigned BUSY_TIMEOUT_DEF = 4096;
  localparam int unsigned GRANT_ID_W       = 3;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: finds the first set bit of 'valid' scanning upward
// from 'rr_ptr' with wrap-around.
// Ports:
//   valid  in  N   candidate requesters
//   rr_ptr in  IW  index with highest priority
//   found  out 1   at least one candidate
//   index  out IW  winning requester index
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  int unsigned j;

  // Rotate, priority-encode and rotate back folded into one scan: step i
  // looks at requester (rr_ptr + i) mod N.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = i + 32'(rr_ptr);
      if (j >= N) j = j - N;
      if (!found && valid[IW'(j)]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit engine between NUM_REQ byte sources.
// Round-robin arbitration, multi-byte messages kept contiguous via a lock,
// stretched trigger for the baud-domain transmitter, busy handshake with a
// per-edge watchdog.
// Ports:
//   clk29m      in   system clock
//   reset       in   asynchronous active-high reset
//   req_valid   in   per-requester byte available
//   req_data    in   byte i at [8i+7:8i]
//   req_last    in   byte i ends its message
//   req_ready   out  one-cycle one-hot accept pulse
//   tx_data     out  byte to transmitter, held until the next accept
//   tx_trig     out  start request, high TRIG_CYCLES cycles
//   tx_busy     in   transmitter busy (baud domain, synchronised here)
//   grant_id    out  current or last granted requester
//   arb_busy    out  high while not idle
//   timeout_err out  sticky watchdog flag
//   clr_err     in   clears timeout_err (a simultaneous timeout wins)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                    clk29m,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_trig,
  input  logic                    tx_busy,
  output logic [GRANT_ID_W-1:0]   grant_id,
  output logic                    arb_busy,
  output logic                    timeout_err,
  input  logic                    clr_err
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned TW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned WW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(BUSY_TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  arb_state_e      state_q;
  logic            busy_meta_q;
  logic            busy_sync_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   gnt_q;
  logic            lock_q;
  logic [TW-1:0]   trig_cnt_q;
  logic [WW-1:0]   wd_cnt_q;

  logic            rr_found;
  logic [IW-1:0]   rr_index;

  logic            win_found_d;
  logic [IW-1:0]   win_idx_d;
  logic [7:0]      win_data_d;
  logic            win_last_d;
  logic [NUM_REQ-1:0] win_onehot_d;
  logic [IW-1:0]   rr_ptr_d;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (rr_found),
    .index  (rr_index)
  );

  assign grant_id = GRANT_ID_W'(gnt_q);

  // While locked only the lock holder may win, regardless of rr_ptr.
  always_comb begin
    win_found_d = rr_found;
    win_idx_d   = rr_index;
    if (lock_q) begin
      win_found_d = req_valid[gnt_q];
      win_idx_d   = gnt_q;
    end

    win_data_d   = '0;
    win_last_d   = 1'b0;
    win_onehot_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx_d == IW'(i)) begin
        win_data_d      = req_data[8*i +: 8];
        win_last_d      = req_last[i];
        win_onehot_d[i] = 1'b1;
      end
    end

    rr_ptr_d = (win_idx_d == LAST_IDX) ? '0 : win_idx_d + IW'(1);
  end

  always_ff @(posedge clk29m or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      lock_q      <= 1'b0;
      trig_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      req_ready   <= '0;
      tx_data     <= '0;
      tx_trig     <= 1'b0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy_meta_q <= tx_busy;
      busy_sync_q <= busy_meta_q;
      req_ready   <= '0;

      // A timeout below overrides this clear in the same cycle.
      if (clr_err) timeout_err <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (win_found_d) begin
            req_ready  <= win_onehot_d;
            tx_data    <= win_data_d;
            gnt_q      <= win_idx_d;
            lock_q     <= ~win_last_d;
            if (win_last_d) rr_ptr_q <= rr_ptr_d;
            trig_cnt_q <= '0;
            arb_busy   <= 1'b1;
            state_q    <= ST_TRIG;
          end
        end

        // First TRIG cycle is the accept cycle; tx_trig rises one cycle
        // later and stays up for exactly TRIG_CYCLES cycles.
        ST_TRIG: begin
          if (trig_cnt_q == TRIG_LAST) begin
            tx_trig  <= 1'b0;
            wd_cnt_q <= '0;
            state_q  <= ST_WAIT_BUSY;
          end else begin
            tx_trig    <= 1'b1;
            trig_cnt_q <= trig_cnt_q + TW'(1);
          end
        end

        ST_WAIT_BUSY: begin
          if (busy_sync_q) begin
            wd_cnt_q <= '0;
            state_q  <= ST_WAIT_DONE;
          end else if (wd_cnt_q == WD_LIMIT) begin
            timeout_err <= 1'b1;
            lock_q      <= 1'b0;
            arb_busy    <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
          end
        end

        ST_WAIT_DONE: begin
          if (!busy_sync_q) begin
            arb_busy <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (wd_cnt_q == WD_LIMIT) begin
            timeout_err <= 1'b1;
            lock_q      <= 1'b0;
            arb_busy    <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
          end
        end

        default: begin
          arb_busy <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: per-requester byte sources,
// a behavioural transmitter, and a monitor that checks every accept and
// every trigger pulse against expectations queued by the stimulus.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TRIG = 16;
  localparam int unsigned TMO  = 4096;

  logic              clk29m = 1'b0;
  logic              reset  = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_trig;
  logic              tx_busy;
  logic [2:0]        grant_id;
  logic              arb_busy;
  logic              timeout_err;
  logic              clr_err = 1'b0;

  always #17 clk29m = ~clk29m;

  uart_tx_arbiter #(
    .NUM_REQ      (NREQ),
    .TRIG_CYCLES  (TRIG),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk29m      (clk29m),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_trig     (tx_trig),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte sources
  logic [7:0] src_data [NREQ][8];
  logic       src_last [NREQ][8];
  int         src_cnt  [NREQ] = '{default: 0};
  int         src_pos  [NREQ] = '{default: 0};

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic add_byte(input int id, input logic [7:0] d, input logic l);
    src_data[id][src_cnt[id]] = d;
    src_last[id][src_cnt[id]] = l;
    src_cnt[id]++;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 3'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit drained();
    for (int i = 0; i < NREQ; i++)
      if (src_pos[i] < src_cnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : driver
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk29m);
      for (int i = 0; i < NREQ; i++) begin
        if (src_pos[i] < src_cnt[i]) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = src_data[i][src_pos[i]];
          req_last[i]       = src_last[i][src_pos[i]];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  // Behavioural transmitter: busy rises 20 cycles after a trigger rise.
  int   busy_len = 40;
  logic xmit_en  = 1'b1;

  initial begin : xmit
    logic pv;
    pv      = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk29m);
      if (tx_trig && !pv && xmit_en && !reset) begin
        for (int k = 0; k < 20 && !reset; k++) @(negedge clk29m);
        if (!reset) tx_busy = 1'b1;
        for (int k = 0; k < busy_len && !reset; k++) @(negedge clk29m);
        tx_busy = 1'b0;
      end
      pv = tx_trig;
    end
  end

  int acc_cnt = 0;

  initial begin : monitor
    logic ready_prev, trig_prev, rst_seen;
    int   trig_len;
    exp_t e;
    ready_prev = 1'b0;
    trig_prev  = 1'b0;
    rst_seen   = 1'b0;
    trig_len   = 0;
    forever begin
      @(posedge clk29m);
      #1;
      if (reset) rst_seen = 1'b1;
      if (req_ready != '0) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_accept", 32'(req_ready), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("req_ready_onehot", 32'(req_ready), 32'(1) << e.id);
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
        for (int i = 0; i < NREQ; i++)
          if (req_ready[i] && src_pos[i] < src_cnt[i]) src_pos[i]++;
      end
      if (tx_trig && !trig_prev) begin
        check("trig_after_ready", 32'(ready_prev), 32'h1);
        trig_len = 1;
        rst_seen = 1'b0;
      end else if (tx_trig) begin
        trig_len++;
      end else if (trig_prev && !rst_seen) begin
        check("trig_len", 32'(trig_len), 32'(TRIG));
      end
      ready_prev = (req_ready != '0);
      trig_prev  = tx_trig;
    end
  end

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while (!(drained() && exp_q.size() == 0 && !arb_busy) && n < budget) begin
      @(posedge clk29m);
      #1;
      n++;
    end
    check({name, "_complete"}, 32'(n < budget), 32'h1);
  endtask

  task automatic wait_trig_fall(input string name, input int budget);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < budget) begin
      @(posedge clk29m);
      #1;
      n++;
      if (tx_trig) seen = 1'b1;
      else if (seen) break;
    end
    check({name, "_trig_fall"}, 32'(seen && !tx_trig), 32'h1);
  endtask

  initial begin : global_limit
    repeat (60000) @(posedge clk29m);
    $display("FAIL global_timeout: simulation exceeded cycle budget");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  initial begin : stim
    int  n;
    bit  seen;

    repeat (3) @(negedge clk29m);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_trig", 32'(tx_trig), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_arb_busy", 32'(arb_busy), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk29m);
    #1;

    // Round-robin lap from rr_ptr=0
    add_byte(0, 8'h10, 1'b1); add_byte(1, 8'h20, 1'b1);
    add_byte(2, 8'h30, 1'b1); add_byte(3, 8'h40, 1'b1);
    add_byte(0, 8'h11, 1'b1);
    expect_grant(0, 8'h10); expect_grant(1, 8'h20); expect_grant(2, 8'h30);
    expect_grant(3, 8'h40); expect_grant(0, 8'h11);
    wait_drained("rr", 3000);

    // Message lock: rr_ptr=1, req1 holds the engine for three bytes
    add_byte(1, 8'hA0, 1'b0); add_byte(1, 8'hA1, 1'b0); add_byte(1, 8'hA2, 1'b1);
    add_byte(0, 8'hB0, 1'b1); add_byte(3, 8'hB3, 1'b1);
    expect_grant(1, 8'hA0); expect_grant(1, 8'hA1); expect_grant(1, 8'hA2);
    expect_grant(3, 8'hB3); expect_grant(0, 8'hB0);
    wait_drained("lock", 3000);

    // Single byte with a long busy window
    busy_len = 2432;
    add_byte(2, 8'h41, 1'b1);
    expect_grant(2, 8'h41);
    n = 0; seen = 1'b0;
    while (n < 3000) begin
      @(posedge clk29m);
      #1;
      n++;
      if (tx_busy) seen = 1'b1;
      else if (seen) break;
    end
    check("single_busy_fall_seen", 32'(seen && !tx_busy), 32'h1);
    check("single_tx_data_held", 32'(tx_data), 32'h41);
    check("single_arb_busy_sync1", 32'(arb_busy), 32'h1);
    @(posedge clk29m); #1;
    check("single_arb_busy_sync2", 32'(arb_busy), 32'h1);
    @(posedge clk29m); #1;
    check("single_arb_busy_idle", 32'(arb_busy), 32'h0);
    busy_len = 40;
    wait_drained("single", 200);

    // Watchdog: locked byte from req3, busy never rises
    xmit_en = 1'b0;
    add_byte(3, 8'hC3, 1'b0);
    expect_grant(3, 8'hC3);
    wait_trig_fall("tmo1", 200);
    n = 0;
    while (!timeout_err && n < 5000) begin
      @(posedge clk29m);
      #1;
      n++;
    end
    check("tmo1_window", 32'(n inside {[TMO:TMO+2]}), 32'h1);
    check("tmo1_err", 32'(timeout_err), 32'h1);
    check("tmo1_arb_idle", 32'(arb_busy), 32'h0);
    // Lock must be gone: req3 no longer valid, req0 gets served
    xmit_en = 1'b1;
    add_byte(0, 8'hD0, 1'b1);
    expect_grant(0, 8'hD0);
    wait_drained("tmo1_next", 300);
    @(negedge clk29m); clr_err = 1'b1;
    @(negedge clk29m); clr_err = 1'b0;
    #1;
    check("clr_err_clears", 32'(timeout_err), 32'h0);

    // Second timeout with clr_err held: the set wins
    xmit_en = 1'b0;
    add_byte(1, 8'hE1, 1'b1);
    expect_grant(1, 8'hE1);
    wait_trig_fall("tmo2", 200);
    @(negedge clk29m); clr_err = 1'b1;
    n = 0;
    while (!timeout_err && n < 5000) begin
      @(posedge clk29m);
      #1;
      n++;
    end
    check("tmo2_set_wins", 32'(timeout_err), 32'h1);
    @(negedge clk29m); clr_err = 1'b0;
    @(posedge clk29m); #1;
    check("tmo2_err_held", 32'(timeout_err), 32'h1);
    xmit_en = 1'b1;
    wait_drained("tmo2", 300);

    // Reset while tx_trig is high
    add_byte(2, 8'h62, 1'b1);
    expect_grant(2, 8'h62);
    n = 0;
    while (!tx_trig && n < 100) begin
      @(posedge clk29m);
      #1;
      n++;
    end
    repeat (4) @(posedge clk29m);
    #1;
    check("trig_high_before_reset", 32'(tx_trig), 32'h1);
    @(negedge clk29m); #2;
    reset = 1'b1;
    #1;
    check("rst_trig_async_drop", 32'(tx_trig), 32'h0);
    check("rst_trig_arb_busy", 32'(arb_busy), 32'h0);
    repeat (2) @(negedge clk29m);
    reset = 1'b0;
    repeat (2) @(posedge clk29m);
    #1;

    // Reset during WAIT_DONE of a locked byte
    busy_len = 200;
    add_byte(2, 8'h72, 1'b0);
    expect_grant(2, 8'h72);
    n = 0;
    while (!tx_busy && n < 200) begin
      @(posedge clk29m);
      #1;
      n++;
    end
    repeat (10) @(posedge clk29m);
    #1;
    check("wait_done_arb_busy", 32'(arb_busy), 32'h1);
    @(negedge clk29m); #2;
    reset = 1'b1;
    #1;
    check("rst_wd_tx_trig", 32'(tx_trig), 32'h0);
    check("rst_wd_arb_busy", 32'(arb_busy), 32'h0);
    check("rst_wd_grant_id", 32'(grant_id), 32'h0);
    check("rst_wd_tx_data", 32'(tx_data), 32'h0);
    check("rst_wd_timeout_err", 32'(timeout_err), 32'h0);
    repeat (2) @(negedge clk29m);
    reset = 1'b0;
    busy_len = 40;
    repeat (2) @(posedge clk29m);
    #1;
    add_byte(0, 8'h80, 1'b1); add_byte(3, 8'h93, 1'b1);
    expect_grant(0, 8'h80); expect_grant(3, 8'h93);
    wait_drained("post_reset", 500);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
